md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit in the E stage of the five-stage MIPS pipeline. Executes `mult`, `multu`, `div` and `divu` over several cycles into private HI/LO registers, and serves `mfhi`, `mflo`, `mthi` and `mtlo`. It drives the busy indication consumed by the forwarding/stall unit. That unit stalls any md-class instruction in D while this block is starting or busy, so the unit never receives a new request while an operation is in flight.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `E_md_start` input 1: E-stage instruction is `mult`/`multu`/`div`/`divu`; valid for exactly one cycle per instruction.
- `E_md_op` input 3: operation code from `const.v` (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MFHI, MD_MFLO, MD_MTHI, MD_MTLO, MD_NONE).
- `E_A` input 32: forwarded rs value.
- `E_B` input 32: forwarded rt value.
- `md_busy` output 1: operation in progress (registered).
- `md_stall_req` output 1: `md_busy | E_md_start`. The stall unit ANDs this with "D instruction is md-class".
- `md_out` output 32: HI for MD_MFHI, LO for MD_MFLO, 0 otherwise (combinational).
- `HI` output 32, `LO` output 32: current architectural register values.

## Operation
- States: IDLE, RUN. Reset puts the block in IDLE with counter=0, HI=0, LO=0, `md_busy`=0, and all operand/result latches cleared.
- IDLE and `E_md_start`=1:
  - Latch `E_A`, `E_B` and op.
  - Load counter with MULT_CYCLES or DIV_CYCLES for the op class.
  - Go to RUN.
  - The result is computed at start and held in internal result registers, which are not yet architectural.
- RUN: decrement the counter each cycle. When the counter reaches 1, go to IDLE on the next edge and commit the result to HI/LO on that same edge.
- Arithmetic:
  - `mult`: {HI,LO} = signed 64-bit product.
  - `multu`: {HI,LO} = unsigned 64-bit product.
  - `div`: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - `divu`: LO and HI from unsigned divide.
  - 0x80000000 / -1 (`div`): LO=0x80000000, HI=0.
  - Divide by zero (`div` or `divu`): the op runs its full DIV_CYCLES, then HI and LO keep their prior values.
- MD_MTHI / MD_MTLO when IDLE and not starting: HI (or LO) takes `E_A` at the next edge. Zero latency otherwise; no busy.
- MD_MFHI / MD_MFLO: `md_out` reflects the current HI/LO combinationally. During RUN it returns the pre-operation value; the stall unit guarantees this never happens architecturally.
- Protocol violation: `E_md_start` or mt* while `md_busy`=1 is ignored (no state change). The bench checks that this never happens in the integrated pipeline.
- `reset` asserted mid-RUN: immediate return to IDLE. HI=LO=0; the pending result is discarded.

## Timing
- Start sampled at edge N:
  - `md_busy`=1 from after edge N through edge N+MULT_CYCLES (or N+DIV_CYCLES).
  - HI/LO update and `md_busy` falls on that same final edge.
- Busy window is therefore exactly 5 (mult) or 10 (div) cycles. An `mfhi` held in D issues in the first cycle with `md_busy`=0 and reads the new value.
- `md_stall_req` is high in the start cycle itself, since it is combinational from `E_md_start`, and in every busy cycle.
- Back-to-back: a new start may be accepted in the first IDLE cycle after completion.
- mt* writes HI/LO at the next edge; a following mf* in the next cycle sees the new value.

## Structure
- `const.v` gains:
  - MD_* op codes (3-bit).
  - `MD_MULT_CYCLES`/`MD_DIV_CYCLES` defaults.
  - InstrType code `md`, used by the stall unit for md-class detection.
- No sub-module: the state register, counter, result latches and HI/LO all sit in one module. Divider and multiplier use the Verilog `*`, `/` and `%` operators on latched operands.

## Test plan
- `mult` A=0xFFFFFFFD (-3), B=5 → `md_busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- `multu` A=0xFFFFFFFF, B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- `div` A=-7 (0xFFFFFFF9), B=2 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. `divu` 7/2 → LO=3, HI=1.
- `mthi` 0x1234 then `div` by 0 → busy 10 cycles, HI stays 0x1234; `mfhi` then gives `md_out`=0x1234.
- `E_md_start` pulsed again at busy cycle 3 of a mult → ignored; result and completion timing are those of the first op.
- `reset` low at busy cycle 4 of a div → `md_busy`=0, HI=LO=0 immediately. After release, `mtlo` 0xA5A5A5A5 → LO=0xA5A5A5A5 next cycle.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared op codes, cycle defaults, state/result types and the arithmetic helper for md_unit.
// Latency and backpressure are owned by md_unit; nothing here is sequential.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MFHI  = 3'd4,
        MD_MFLO  = 3'd5,
        MD_MTHI  = 3'd6,
        MD_MTLO  = 3'd7
    } md_op_t;

    // Eight real ops fill the 3-bit code, so "none" shares MD_MULT's encoding:
    // MD_MULT only acts together with E_md_start, so it is inert on its own.
    localparam md_op_t MD_NONE = MD_MULT;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    // InstrType code the stall unit uses to recognise md-class instructions in D.
    localparam logic [3:0] ITYPE_MD = 4'd9;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] hi;
        logic [31:0] lo;
    } md_res_t;

    function automatic logic md_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic md_res_t md_compute(input md_op_t op, input logic [31:0] a,
                                           input logic [31:0] b);
        md_res_t            r;
        logic [63:0]        p;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        r  = '0;
        p  = '0;
        sa = a;
        sb = b;
        case (op)
            MD_MULT: begin
                // Low 64 bits of the sign-extended product equal the signed product.
                p    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                r.wr = 1'b1;
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            MD_MULTU: begin
                p    = {32'b0, a} * {32'b0, b};
                r.wr = 1'b1;
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            MD_DIV: begin
                if (b == 32'h0) begin
                    r.wr = 1'b0;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.wr = 1'b1;
                    r.lo = 32'h8000_0000;
                    r.hi = 32'h0;
                end else begin
                    r.wr = 1'b1;
                    r.lo = sa / sb;
                    r.hi = sa % sb;
                end
            end
            MD_DIVU: begin
                if (b != 32'h0) begin
                    r.wr = 1'b1;
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
            default: r.wr = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle mult/div into private HI/LO plus mf*/mt* access; result lands MULT_CYCLES/DIV_CYCLES edges after start.
// No backpressure: md_stall_req holds the upstream md-class instruction; starts or mt* while busy are dropped.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_md_start,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        md_busy,
    output logic        md_stall_req,
    output logic [31:0] md_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_t   state;
    logic [7:0]  cnt;
    md_res_t     res;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    md_op_t      op;

    assign op           = md_op_t'(E_md_op);
    assign md_stall_req = md_busy | E_md_start;
    assign HI           = hi_q;
    assign LO           = lo_q;

    always_comb begin
        md_out = 32'h0;
        case (op)
            MD_MFHI: md_out = hi_q;
            MD_MFLO: md_out = lo_q;
            default: md_out = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= MD_IDLE;
            cnt     <= 8'd0;
            res     <= '0;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
            md_busy <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (E_md_start) begin
                        // Result is captured now; HI/LO stay architectural until the final edge.
                        res     <= md_compute(op, E_A, E_B);
                        cnt     <= md_is_div(op) ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
                        state   <= MD_RUN;
                        md_busy <= 1'b1;
                    end else if (op == MD_MTHI) begin
                        hi_q <= E_A;
                    end else if (op == MD_MTLO) begin
                        lo_q <= E_A;
                    end
                end
                MD_RUN: begin
                    if (cnt == 8'd1) begin
                        state   <= MD_IDLE;
                        md_busy <= 1'b0;
                        cnt     <= 8'd0;
                        if (res.wr) begin
                            hi_q <= res.hi;
                            lo_q <= res.lo;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Randomised and directed bench for md_unit against a plain-arithmetic HI/LO model.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_md_start;
    logic [2:0]  E_md_op;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        md_busy;
    logic        md_stall_req;
    logic [31:0] md_out;
    logic [31:0] HI;
    logic [31:0] LO;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .E_md_start(E_md_start), .E_md_op(E_md_op),
        .E_A(E_A), .E_B(E_B), .md_busy(md_busy), .md_stall_req(md_stall_req),
        .md_out(md_out), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    function automatic int exp_cycles(input md_op_t op);
        return (op == MD_DIV || op == MD_DIVU) ? DC : MC;
    endfunction

    task automatic model_md(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa;
        int              sb;
        int              q;
        logic [63:0]     w;
        sa = a;
        sb = b;
        case (op)
            MD_MULT: begin
                sp = longint'(sa) * longint'(sb);
                w = sp;
                m_hi = w[63:32];
                m_lo = w[31:0];
            end
            MD_MULTU: begin
                up = 64'(a) * 64'(b);
                w = up;
                m_hi = w[63:32];
                m_lo = w[31:0];
            end
            MD_DIV: begin
                if (b == 0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'h0;
                end else begin
                    q = sa / sb;
                    m_lo = q;
                    m_hi = sa - q * sb;
                end
            end
            MD_DIVU: begin
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a - (a / b) * b;
                end
            end
            default: ;
        endcase
    endtask

    task automatic start_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        E_md_start = 1'b1;
        E_md_op    = op;
        E_A        = a;
        E_B        = b;
    endtask

    // Counts busy cycles; inj>0 drives a stray start at that busy cycle and an mthi one cycle later.
    task automatic wait_idle(input int inj, output int n, output bit stable, output bit stall_ok);
        logic [31:0] ph;
        logic [31:0] pl;
        ph = HI;
        pl = LO;
        n = 0;
        stable = 1'b1;
        stall_ok = 1'b1;
        @(negedge clk);
        while (md_busy === 1'b1 && n < 64) begin
            n++;
            if (HI !== ph || LO !== pl) stable = 1'b0;
            if (md_stall_req !== 1'b1) stall_ok = 1'b0;
            E_md_start = 1'b0;
            E_md_op = MD_NONE;
            if (n == inj) begin
                E_md_start = 1'b1;
                E_md_op = MD_DIV;
                E_A = $urandom;
                E_B = $urandom | 32'h1;
            end
            if (n == inj + 1) begin
                E_md_op = MD_MTHI;
                E_A = 32'hDEAD_BEEF;
            end
            @(negedge clk);
        end
        E_md_start = 1'b0;
        E_md_op = MD_NONE;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        E_md_start = 1'b0;
        E_md_op = MD_MFHI;
        E_A = 32'h0;
        E_B = 32'h0;
        #2;
        n_checks++;
        if (md_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", md_busy); else n_pass++;
        n_checks++;
        if (HI !== 32'h0 || LO !== 32'h0) $display("FAIL reset_hilo: got %h/%h want 0/0", HI, LO); else n_pass++;
        n_checks++;
        if (md_out !== 32'h0 || md_stall_req !== 1'b0)
            $display("FAIL reset_out: md_out %h stall %b want 0/0", md_out, md_stall_req);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        E_md_op = MD_NONE;
        m_hi = 32'h0;
        m_lo = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_mt_mf();
        logic [31:0] r1;
        logic [31:0] r2;
        r1 = $urandom;
        r2 = $urandom;
        E_md_op = MD_MTHI;
        E_A = r1;
        #1;
        n_checks++;
        if (md_busy !== 1'b0 || md_stall_req !== 1'b0)
            $display("FAIL mt_nobusy: busy %b stall %b want 0/0", md_busy, md_stall_req);
        else n_pass++;
        @(negedge clk);
        E_md_op = MD_MTLO;
        E_A = r2;
        @(negedge clk);
        E_md_op = MD_MFHI;
        #1;
        n_checks++;
        if (HI !== r1 || md_out !== r1) $display("FAIL mthi_mfhi: HI %h md_out %h want %h", HI, md_out, r1); else n_pass++;
        E_md_op = MD_MFLO;
        #1;
        n_checks++;
        if (LO !== r2 || md_out !== r2) $display("FAIL mtlo_mflo: LO %h md_out %h want %h", LO, md_out, r2); else n_pass++;
        m_hi = r1;
        m_lo = r2;
        E_md_op = MD_NONE;
        @(negedge clk);
    endtask

    task automatic test_arith(input string name, input md_op_t op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        bit stable;
        bit stall_ok;
        start_op(op, a, b);
        #1;
        n_checks++;
        if (md_stall_req !== 1'b1 || md_busy !== 1'b0)
            $display("FAIL %s_startcyc: stall %b busy %b want 1/0", name, md_stall_req, md_busy);
        else n_pass++;
        wait_idle(-1, n, stable, stall_ok);
        n_checks++;
        if (n !== exp_cycles(op) || !stable || !stall_ok)
            $display("FAIL %s_busy: cycles %0d stable %b stall %b want %0d/1/1", name, n, stable, stall_ok, exp_cycles(op));
        else n_pass++;
        E_md_op = MD_MFHI;
        #1;
        n_checks++;
        if (HI !== eh || LO !== el || md_out !== eh)
            $display("FAIL %s_result: HI %h LO %h md_out %h want %h %h", name, HI, LO, md_out, eh, el);
        else n_pass++;
        E_md_op = MD_NONE;
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic test_div0();
        int n;
        bit stable;
        bit stall_ok;
        E_md_op = MD_MTHI;
        E_A = 32'h0000_1234;
        @(negedge clk);
        E_md_op = MD_NONE;
        m_hi = 32'h0000_1234;
        start_op(MD_DIV, $urandom, 32'h0);
        wait_idle(-1, n, stable, stall_ok);
        n_checks++;
        if (n !== DC) $display("FAIL div0_busy: cycles %0d want %0d", n, DC); else n_pass++;
        E_md_op = MD_MFHI;
        #1;
        n_checks++;
        if (HI !== 32'h1234 || LO !== m_lo || md_out !== 32'h1234)
            $display("FAIL div0_keep: HI %h LO %h md_out %h want 1234 %h", HI, LO, md_out, m_lo);
        else n_pass++;
        E_md_op = MD_NONE;
        start_op(MD_DIVU, $urandom, 32'h0);
        wait_idle(-1, n, stable, stall_ok);
        n_checks++;
        if (n !== DC || HI !== m_hi || LO !== m_lo)
            $display("FAIL divu0_keep: cycles %0d HI %h LO %h want %0d %h %h", n, HI, LO, DC, m_hi, m_lo);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        int n;
        bit stable;
        bit stall_ok;
        start_op(MD_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_idle(3, n, stable, stall_ok);
        n_checks++;
        if (n !== MC) $display("FAIL ignore_timing: cycles %0d want %0d", n, MC); else n_pass++;
        n_checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFF1)
            $display("FAIL ignore_result: HI %h LO %h want ffffffff fffffff1", HI, LO);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (md_busy !== 1'b0 || HI !== 32'hFFFF_FFFF)
            $display("FAIL ignore_after: busy %b HI %h want 0 ffffffff", md_busy, HI);
        else n_pass++;
        m_hi = 32'hFFFF_FFFF;
        m_lo = 32'hFFFF_FFF1;
    endtask

    task automatic test_reset_mid();
        bit quiet;
        start_op(MD_DIV, 32'd100, 32'd7);
        @(negedge clk);
        E_md_start = 1'b0;
        E_md_op = MD_NONE;
        repeat (3) @(negedge clk);
        n_checks++;
        if (md_busy !== 1'b1 || HI !== m_hi) $display("FAIL rmid_pre: busy %b HI %h want 1 %h", md_busy, HI, m_hi); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (md_busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0)
            $display("FAIL rmid_clear: busy %b HI %h LO %h want 0 0 0", md_busy, HI, LO);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        m_hi = 32'h0;
        m_lo = 32'h0;
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (md_busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) $display("FAIL rmid_discard: busy %b HI %h LO %h want 0 0 0", md_busy, HI, LO); else n_pass++;
        E_md_op = MD_MTLO;
        E_A = 32'hA5A5_A5A5;
        @(negedge clk);
        E_md_op = MD_MFLO;
        #1;
        n_checks++;
        if (LO !== 32'hA5A5_A5A5 || md_out !== 32'hA5A5_A5A5)
            $display("FAIL rmid_mtlo: LO %h md_out %h want a5a5a5a5", LO, md_out);
        else n_pass++;
        E_md_op = MD_NONE;
        m_lo = 32'hA5A5_A5A5;
    endtask

    task automatic test_back_to_back();
        md_op_t      ops[4];
        md_op_t      op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        bit          stable;
        bit          stall_ok;
        ops[0] = MD_MULT;
        ops[1] = MD_MULTU;
        ops[2] = MD_DIV;
        ops[3] = MD_DIVU;
        for (int i = 0; i < 16; i++) begin
            op = ops[$urandom_range(0, 3)];
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 9);
                default: b = $urandom;
            endcase
            if (i == 5) begin
                op = MD_DIV;
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            start_op(op, a, b);
            model_md(op, a, b);
            wait_idle(-1, n, stable, stall_ok);
            n_checks++;
            if (n !== exp_cycles(op) || !stable || !stall_ok)
                $display("FAIL b2b_busy[%0d]: op %0d cycles %0d stable %b stall %b want %0d", i, op, n, stable, stall_ok, exp_cycles(op));
            else n_pass++;
            n_checks++;
            if (HI !== m_hi || LO !== m_lo)
                $display("FAIL b2b_result[%0d]: op %0d a %h b %h HI %h LO %h want %h %h", i, op, a, b, HI, LO, m_hi, m_lo);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_mt_mf();
        test_arith("mult", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        test_arith("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        test_arith("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        test_arith("divu", MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        test_arith("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        test_div0();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
